instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//   Upstream feeder of the instruction-fetch stage. Collects program bytes from the debug UART receiver,
//   assembles them MSB-first into instruction words and writes each word into IF instruction memory
//   (drives IF write strobe/data; watches its full flag). Loading ends on the HALT word or on memory-full.
// PARAMETERS
//   WORD_SIZE_IN_BYTES  4     bytes per instruction word; must match IF instruction memory
//   MEM_SIZE_IN_WORDS   64    instruction memory depth; sizes o_word_count
//   BYTE_SIZE           8     width of one rx byte (`BYTE_SIZE)
//   (local) BUS_SIZE = WORD_SIZE_IN_BYTES*BYTE_SIZE; CNT_SIZE = $clog2(MEM_SIZE_IN_WORDS)+1
// PORTS
//   i_clk          in   1         single clock; all state changes on rising edge
//   i_reset        in   1         asynchronous, active-low reset
//   i_start        in   1         one-cycle pulse: begin a new load
//   i_rx_valid     in   1         one-cycle strobe: i_rx_data holds a new byte
//   i_rx_data      in   BYTE_SIZE received byte
//   i_full_mem     in   1         instruction memory full (from IF)
//   o_write_mem    out  1         one-cycle write strobe to IF instruction memory
//   o_instruction  out  BUS_SIZE  assembled word, valid while o_write_mem=1
//   o_busy         out  1         1 in RECV/WRITE
//   o_done         out  1         load finished with HALT word written
//   o_error        out  1         load aborted: memory full before HALT
//   o_word_count   out  CNT_SIZE  words written in current/last load
// BEHAVIOUR
//   Reset (i_reset=0, async): state IDLE; all outputs 0; shift register, byte and word counters 0;
//   any partial word discarded. Reset mid-load is legal and silent.
//   States: IDLE, RECV, WRITE, DONE, ERROR (encoding in shared header).
//   IDLE : i_rx_valid ignored. i_start -> RECV, clear byte count, word count, o_done, o_error.
//   RECV : on i_rx_valid shift word left by BYTE_SIZE, insert byte at LSB (first byte = MSB), byte_cnt++.
//          When the WORD_SIZE_IN_BYTES-th byte is captured -> WRITE next cycle, byte_cnt <= 0.
//          i_start ignored while busy.
//   WRITE: exactly one cycle. If i_full_mem=0: o_write_mem=1, o_instruction=assembled word,
//          o_word_count++ (saturates at MEM_SIZE_IN_WORDS); then word==`INSTRUCTION_HALT -> DONE,
//          else -> RECV. If i_full_mem=1: no write, -> ERROR.
//          An i_rx_valid arriving in WRITE is captured as first byte of the next word (no byte loss).
//   DONE : o_done=1 held; o_word_count held; i_rx_valid ignored; i_start -> RECV (new load).
//   ERROR: o_error=1 held; same exit rules as DONE.
//   Latency: last byte strobe at cycle N -> o_write_mem=1 at cycle N+1; back-to-back bytes every
//   cycle supported (min 1 cycle per byte, sustained).
//   o_write_mem/o_instruction registered; o_instruction holds last written word between writes.
//   o_done and o_error never both 1. HALT word itself is written and counted.
// STRUCTURE
//   Shared header (if.vh): `BYTE_SIZE, `INSTRUCTION_HALT, loader state encodings, default params.
//   One sub-module: word_assembler (shift register + byte counter, outputs word and word_ready).
//   FSM, write strobe and word counter live in instruction_loader.
// TESTING
//   1) reset, start, send 00 00 00 01 then FF FF FF FF -> writes 32'h00000001 then 32'hFFFFFFFF;
//      o_done=1, o_word_count=2, o_error=0.
//   2) bytes 12 34 56 78 on 4 consecutive cycles -> o_write_mem=1 one cycle after byte 78,
//      o_instruction=32'h12345678.
//   3) i_full_mem=1 when 2nd word completes -> no 2nd strobe, o_error=1, o_word_count=1.
//   4) i_reset low after 2 bytes of a word, release, start, send AA BB CC DD -> word 32'hAABBCCDD
//      (old bytes discarded).
//   5) i_rx_valid in IDLE/DONE and i_start during RECV -> no state change, no write.
//   6) byte arriving in WRITE cycle -> becomes MSB of next word; fill MEM_SIZE_IN_WORDS words then
//      send more -> o_error=1, count saturates at 64.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader slice.
//   - Default geometry of the IF instruction memory and the rx byte width.
//   - HALT marker: the all-ones instruction word, built from INSTRUCTION_HALT_BYTE.
//   - Loader FSM state encoding.
package instruction_loader_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE_IN_BYTES = 4;
    localparam int unsigned DEFAULT_MEM_SIZE_IN_WORDS  = 64;
    localparam int unsigned DEFAULT_BYTE_SIZE          = 8;

    // Every byte of the HALT word carries this value.
    localparam logic [7:0] INSTRUCTION_HALT_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Byte-to-word assembler: shifts rx bytes in MSB-first and counts them.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_clear          synchronous clear of shift register and byte counter
//   i_valid, i_byte  byte strobe and data (already gated by the caller)
//   o_word           full word including the byte currently presented
//   o_word_ready     i_valid carries the final byte of a word
module instruction_loader_word_assembler #(
    parameter int unsigned WORD_SIZE_IN_BYTES = 4,
    parameter int unsigned BYTE_SIZE          = 8,
    localparam int unsigned BUS_SIZE          = WORD_SIZE_IN_BYTES * BYTE_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [BYTE_SIZE-1:0] i_byte,
    output logic [BUS_SIZE-1:0]  o_word,
    output logic                 o_word_ready
);

    localparam int unsigned CNT_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_SIZE_IN_BYTES - 1);

    // Only the first WORD_SIZE_IN_BYTES-1 bytes need storage; the last one
    // is taken straight from i_byte so the word is available on its strobe.
    logic [BUS_SIZE-BYTE_SIZE-1:0] shift_q;
    logic [CNT_W-1:0]              byte_cnt_q;

    assign o_word       = {shift_q, i_byte};
    assign o_word_ready = i_valid && (byte_cnt_q == LAST_BYTE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (i_clear) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else if (i_valid) begin
            shift_q    <= o_word[BUS_SIZE-BYTE_SIZE-1:0];
            byte_cnt_q <= o_word_ready ? '0 : byte_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: assembles UART rx bytes into instruction words and
// writes them into the IF instruction memory until HALT or memory full.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   i_start          pulse, begins a new load (ignored while busy)
//   i_rx_valid/data  received byte strobe and value
//   i_full_mem       IF instruction memory full
//   o_write_mem      one-cycle write strobe, o_instruction valid with it
//   o_instruction    last written word (held between writes)
//   o_busy           load in progress (RECV/WRITE)
//   o_done/o_error   load ended on HALT / on memory full
//   o_word_count     words written in current or last load (saturating)
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
    parameter int unsigned MEM_SIZE_IN_WORDS  = DEFAULT_MEM_SIZE_IN_WORDS,
    parameter int unsigned BYTE_SIZE          = DEFAULT_BYTE_SIZE,
    localparam int unsigned BUS_SIZE          = WORD_SIZE_IN_BYTES * BYTE_SIZE,
    localparam int unsigned CNT_SIZE          = $clog2(MEM_SIZE_IN_WORDS) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_rx_valid,
    input  logic [BYTE_SIZE-1:0] i_rx_data,
    input  logic                 i_full_mem,
    output logic                 o_write_mem,
    output logic [BUS_SIZE-1:0]  o_instruction,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [CNT_SIZE-1:0]  o_word_count
);

    localparam logic [BUS_SIZE-1:0] HALT_WORD =
        {WORD_SIZE_IN_BYTES{BYTE_SIZE'(INSTRUCTION_HALT_BYTE)}};
    localparam logic [CNT_SIZE-1:0] COUNT_MAX = CNT_SIZE'(MEM_SIZE_IN_WORDS);

    loader_state_t       state_q, state_d;
    logic                start_load;
    logic                asm_valid;
    logic                word_ready;
    logic                word_accept;
    logic [BUS_SIZE-1:0] word;

    assign start_load  = i_start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
    // A byte landing in WRITE already belongs to the next word.
    assign asm_valid   = i_rx_valid && (state_q == ST_RECV || state_q == ST_WRITE);
    assign word_accept = word_ready && (state_q == ST_RECV);

    instruction_loader_word_assembler #(
        .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES),
        .BYTE_SIZE          (BYTE_SIZE)
    ) u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (start_load),
        .i_valid      (asm_valid),
        .i_byte       (i_rx_data),
        .o_word       (word),
        .o_word_ready (word_ready)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The write strobe is registered on the edge that completes the word, so
    // it is high exactly during the WRITE cycle; a cleared strobe in WRITE
    // therefore means memory was full when the word completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!o_write_mem)                  state_d = ST_ERROR;
                else if (o_instruction == HALT_WORD) state_d = ST_DONE;
                else                               state_d = ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_write_mem   <= 1'b0;
            o_instruction <= '0;
            o_word_count  <= '0;
        end else begin
            o_write_mem <= 1'b0;
            if (start_load) begin
                o_word_count <= '0;
            end else if (word_accept && !i_full_mem) begin
                o_write_mem   <= 1'b1;
                o_instruction <= word;
                if (o_word_count != COUNT_MAX) o_word_count <= o_word_count + 1'b1;
            end
        end
    end

    assign o_busy  = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign o_done  = (state_q == ST_DONE);
    assign o_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_full_mem = 1'b0;
    logic        o_write_mem;
    logic [31:0] o_instruction;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [6:0]  o_word_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] wr_log[$];

    instruction_loader #(
        .WORD_SIZE_IN_BYTES (4),
        .MEM_SIZE_IN_WORDS  (64),
        .BYTE_SIZE          (8)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .i_full_mem    (i_full_mem),
        .o_write_mem   (o_write_mem),
        .o_instruction (o_instruction),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_word_count  (o_word_count)
    );

    always #5 i_clk = ~i_clk;

    // Record every write strobe, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (o_write_mem) wr_log.push_back(o_instruction);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int unsigned k);
        if (wr_log.size() > k) return wr_log[k];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge i_clk);
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Drives four bytes on consecutive cycles, MSB first; leaves i_rx_valid
    // high after the last byte so callers can chain words back to back.
    task automatic drive_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            @(negedge i_clk);
            i_rx_valid = 1'b1;
            i_rx_data  = w[i*8 +: 8];
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        drive_word(w);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_write", {31'd0, o_write_mem}, 32'd0);
        check("rst_instr", o_instruction, 32'd0);
        check("rst_flags", {29'd0, o_busy, o_done, o_error}, 32'd0);
        check("rst_count", {25'd0, o_word_count}, 32'd0);
        i_reset = 1'b1;

        // 1) two words, second is HALT
        wr_log.delete();
        pulse_start();
        check("t1_busy", {31'd0, o_busy}, 32'd1);
        send_word(32'h0000_0001);
        send_word(32'hFFFF_FFFF);
        idle_cycles(3);
        check("t1_nwr", wr_log.size(), 32'd2);
        check("t1_w0", log_at(0), 32'h0000_0001);
        check("t1_w1", log_at(1), 32'hFFFF_FFFF);
        check("t1_flags", {29'd0, o_busy, o_done, o_error}, 32'b010);
        check("t1_count", {25'd0, o_word_count}, 32'd2);

        // 2) latency of one cycle after the last byte, and hold of o_instruction
        wr_log.delete();
        pulse_start();
        check("t2_count_clr", {25'd0, o_word_count}, 32'd0);
        check("t2_done_clr", {31'd0, o_done}, 32'd0);
        drive_word(32'h1234_5678);
        @(posedge i_clk);
        #1;
        check("t2_strobe", {31'd0, o_write_mem}, 32'd1);
        check("t2_instr", o_instruction, 32'h1234_5678);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        idle_cycles(3);
        check("t2_strobe_off", {31'd0, o_write_mem}, 32'd0);
        check("t2_hold", o_instruction, 32'h1234_5678);

        // 5a) start during RECV is ignored
        pulse_start();
        idle_cycles(2);
        check("t5_start_busy", {31'd0, o_busy}, 32'd1);
        check("t5_start_count", {25'd0, o_word_count}, 32'd1);
        send_word(32'hFFFF_FFFF);
        idle_cycles(3);
        check("t5_finish_done", {31'd0, o_done}, 32'd1);
        check("t5_finish_count", {25'd0, o_word_count}, 32'd2);
        check("t2_nwr", wr_log.size(), 32'd2);

        // 3) memory full when the second word completes
        wr_log.delete();
        pulse_start();
        send_word(32'hA0A1_A2A3);
        i_full_mem = 1'b1;
        send_word(32'hB0B1_B2B3);
        idle_cycles(3);
        i_full_mem = 1'b0;
        check("t3_nwr", wr_log.size(), 32'd1);
        check("t3_w0", log_at(0), 32'hA0A1_A2A3);
        check("t3_flags", {29'd0, o_busy, o_done, o_error}, 32'b001);
        check("t3_count", {25'd0, o_word_count}, 32'd1);

        // 4) reset in the middle of a word discards partial bytes
        wr_log.delete();
        pulse_start();
        @(negedge i_clk); i_rx_valid = 1'b1; i_rx_data = 8'h11;
        @(negedge i_clk); i_rx_data = 8'h22;
        @(negedge i_clk); i_rx_valid = 1'b0;
        i_reset = 1'b0;
        #1;
        check("t4_rst_flags", {29'd0, o_busy, o_done, o_error}, 32'd0);
        check("t4_rst_count", {25'd0, o_word_count}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        pulse_start();
        send_word(32'hAABB_CCDD);
        idle_cycles(2);
        check("t4_nwr", wr_log.size(), 32'd1);
        check("t4_w0", log_at(0), 32'hAABB_CCDD);

        // 5b) bytes in IDLE and in DONE are ignored
        do_reset();
        wr_log.delete();
        send_word(32'h0102_0304);
        idle_cycles(2);
        check("t5_idle_nwr", wr_log.size(), 32'd0);
        check("t5_idle_busy", {31'd0, o_busy}, 32'd0);
        pulse_start();
        send_word(32'hFFFF_FFFF);
        idle_cycles(2);
        send_word(32'h0506_0708);
        idle_cycles(3);
        check("t5_done_nwr", wr_log.size(), 32'd1);
        check("t5_done_flags", {29'd0, o_busy, o_done, o_error}, 32'b010);
        check("t5_done_count", {25'd0, o_word_count}, 32'd1);

        // 6) byte during WRITE starts the next word; fill memory then overflow
        wr_log.delete();
        pulse_start();
        drive_word(32'h0102_0304);
        drive_word(32'h0506_0708);
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        idle_cycles(2);
        check("t6_b2b_nwr", wr_log.size(), 32'd2);
        check("t6_b2b_w0", log_at(0), 32'h0102_0304);
        check("t6_b2b_w1", log_at(1), 32'h0506_0708);
        for (int unsigned i = 2; i < 64; i++) send_word(32'h5A00_0000 | i);
        idle_cycles(2);
        check("t6_fill_nwr", wr_log.size(), 32'd64);
        check("t6_fill_last", log_at(63), 32'h5A00_003F);
        check("t6_fill_count", {25'd0, o_word_count}, 32'd64);
        check("t6_fill_busy", {31'd0, o_busy}, 32'd1);
        i_full_mem = 1'b1;
        send_word(32'h0BAD_0BAD);
        idle_cycles(3);
        check("t6_ovf_nwr", wr_log.size(), 32'd64);
        check("t6_ovf_flags", {29'd0, o_busy, o_done, o_error}, 32'b001);
        check("t6_ovf_count", {25'd0, o_word_count}, 32'd64);
        i_full_mem = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
